// File: rtl/div_pkg.sv
// Constants and FSM encoding shared by the divider and the dividend rebuilder.
package div_pkg;

  localparam int QW_DEF  = 32;
  localparam int BW_DEF  = 16;
  localparam int COUNT_W = $clog2(BW_DEF) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/dividend_rebuilder_if.sv
// Start/busy/ready/count handshake plus operand and result bundle.
interface dividend_rebuilder_if #(
  parameter int QW = 32,
  parameter int BW = 16
);
  localparam int CW = $clog2(BW) + 1;

  logic             start;
  logic [QW-1:0]    q_in;
  logic [BW-1:0]    b_in;
  logic [BW-1:0]    r_in;
  logic [QW+BW-1:0] a_out;
  logic             ovf;
  logic             rem_err;
  logic             busy;
  logic             ready;
  logic [CW-1:0]    count;

  modport master (
    output start, q_in, b_in, r_in,
    input  a_out, ovf, rem_err,
    input  busy, ready, count
  );

  modport slave (
    input  start, q_in, b_in, r_in,
    output a_out, ovf, rem_err,
    output busy, ready, count
  );

endinterface

// File: rtl/dividend_rebuilder.sv
// Shift-add rebuild of a divider dividend: a = q*b + r, one divisor bit per clock.
module dividend_rebuilder
  import div_pkg::*;
#(
  parameter int QW = QW_DEF,
  parameter int BW = BW_DEF
) (
  input  logic                 clk,
  input  logic                 clr,
  dividend_rebuilder_if.slave  bus
);

  localparam int AW = QW + BW;
  localparam int CW = $clog2(BW) + 1;

  state_e        state_q;
  logic [AW-1:0] acc_q;
  logic [AW-1:0] acc_d;
  logic [AW-1:0] mcand_q;
  logic [BW-1:0] mplier_q;
  logic [CW-1:0] count_q;
  logic [AW-1:0] a_out_q;
  logic          ovf_q;
  logic          rem_err_q;

  // acc starts at r, so the final value already includes the remainder
  assign acc_d = mplier_q[0] ? acc_q + mcand_q : acc_q;

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      count_q   <= '0;
      a_out_q   <= '0;
      ovf_q     <= 1'b0;
      rem_err_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (bus.start) begin
            state_q   <= RUN;
            acc_q     <= {{QW{1'b0}}, bus.r_in};
            mcand_q   <= {{BW{1'b0}}, bus.q_in};
            mplier_q  <= bus.b_in;
            count_q   <= '0;
            rem_err_q <= bus.r_in >= bus.b_in;
          end
        end
        RUN: begin
          acc_q    <= acc_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          count_q  <= count_q + 1'b1;
          if (count_q == CW'(BW - 1)) begin
            state_q <= DONE;
            a_out_q <= acc_d;
            ovf_q   <= |acc_d[AW-1:QW];
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.a_out   = a_out_q;
  assign bus.ovf     = ovf_q;
  assign bus.rem_err = rem_err_q;
  assign bus.busy    = state_q == RUN;
  assign bus.ready   = state_q == DONE;
  assign bus.count   = count_q;

endmodule

// File: tb/tb_dividend_rebuilder.sv
// Scoreboard bench for dividend_rebuilder: latency, result, flags, lockout, reset.
module tb_dividend_rebuilder;

  localparam int QW = 32;
  localparam int BW = 16;
  localparam int AW = QW + BW;
  localparam int LAT = 16;
  localparam int TMO = 40;

  typedef struct {
    logic [AW-1:0] a;
    logic          ovf;
    logic          rem_err;
  } exp_t;

  logic clk = 1'b0;
  logic clr = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;
  exp_t sb[$];
  logic rdy_prev = 1'b0;

  dividend_rebuilder_if #(.QW(QW), .BW(BW)) bus ();

  dividend_rebuilder #(.QW(QW), .BW(BW)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // monitor: every rising ready retires one scoreboard entry
  always @(negedge clk) begin
    exp_t e;
    if (bus.ready && !rdy_prev) begin
      n_vec++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL sb_empty: ready rose with no expectation");
      end else begin
        e = sb.pop_front();
        n_vec += 3;
        if (bus.a_out !== e.a) begin
          n_err++;
          $display("FAIL a_out: got %h exp %h", bus.a_out, e.a);
        end
        if (bus.ovf !== e.ovf) begin
          n_err++;
          $display("FAIL ovf: got %b exp %b", bus.ovf, e.ovf);
        end
        if (bus.rem_err !== e.rem_err) begin
          n_err++;
          $display("FAIL rem_err: got %b exp %b",
                   bus.rem_err, e.rem_err);
        end
        if (bus.count !== 5'(BW)) begin
          n_err++;
          $display("FAIL count: got %0d exp %0d", bus.count, BW);
        end
      end
    end
    rdy_prev = bus.ready;
  end

  function automatic exp_t model(logic [QW-1:0] q,
                                 logic [BW-1:0] b,
                                 logic [BW-1:0] r);
    exp_t e;
    e.a       = AW'(q) * AW'(b) + AW'(r);
    e.ovf     = e.a[AW-1:QW] != '0;
    e.rem_err = r >= b;
    return e;
  endfunction

  // drive a start for one cycle; returns at the negedge after the load edge
  task automatic launch(logic [QW-1:0] q, logic [BW-1:0] b,
                        logic [BW-1:0] r, bit push);
    bus.q_in  = q;
    bus.b_in  = b;
    bus.r_in  = r;
    bus.start = 1'b1;
    if (push) sb.push_back(model(q, b, r));
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    bus.q_in  = $urandom;
    bus.b_in  = 16'($urandom);
    bus.r_in  = 16'($urandom);
  endtask

  task automatic wait_ready(inout int lat);
    while (!bus.ready && lat < TMO) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    n_vec++;
    if ({bus.a_out, bus.ovf, bus.rem_err, bus.busy,
         bus.ready, bus.count} !== '0) begin
      n_err++;
      $display("FAIL reset: got a=%h ovf=%b re=%b busy=%b rdy=%b cnt=%0d exp all 0",
               bus.a_out, bus.ovf, bus.rem_err, bus.busy,
               bus.ready, bus.count);
    end
  endtask

  task automatic test_vectors;
    logic [QW-1:0] qt[7];
    logic [BW-1:0] bt[7];
    logic [BW-1:0] rt[7];
    qt = '{32'h0000B8A6, 32'hFFFFFFFF, 32'h12345678, 0, 0, 0, 0};
    bt = '{16'h6A0E, 16'hFFFF, 16'h0000, 0, 0, 0, 0};
    rt = '{16'h4D76, 16'hFFFE, 16'h00AB, 0, 0, 0, 0};
    for (int i = 3; i < 7; i++) begin
      qt[i] = $urandom;
      bt[i] = 16'($urandom);
      rt[i] = 16'($urandom);
    end
    for (int i = 0; i < 7; i++) begin
      int lat = 0;
      launch(qt[i], bt[i], rt[i], 1'b1);
      n_vec++;
      if (bus.ready !== 1'b0 || bus.busy !== 1'b1) begin
        n_err++;
        $display("FAIL load_flags[%0d]: got rdy=%b busy=%b exp 0/1",
                 i, bus.ready, bus.busy);
      end
      wait_ready(lat);
      n_vec++;
      if (lat != LAT) begin
        n_err++;
        $display("FAIL latency[%0d]: got %0d exp %0d", i, lat, LAT);
      end
      repeat (2) @(negedge clk);
      n_vec++;
      if (bus.ready !== 1'b1) begin
        n_err++;
        $display("FAIL ready_hold[%0d]: got %b exp 1", i, bus.ready);
      end
    end
  endtask

  task automatic test_busy_lockout;
    int lat = 0;
    launch(32'h0000B8A6, 16'h6A0E, 16'h4D76, 1'b1);
    while (bus.count != 5'd5 && lat < TMO) begin
      @(negedge clk);
      lat++;
    end
    bus.q_in  = 32'd1;
    bus.b_in  = 16'd1;
    bus.r_in  = 16'd0;
    bus.start = 1'b1;
    @(negedge clk);
    lat++;
    bus.start = 1'b0;
    n_vec++;
    if (bus.busy !== 1'b1 || bus.count !== 5'd6) begin
      n_err++;
      $display("FAIL lockout_run: got busy=%b cnt=%0d exp 1/6",
               bus.busy, bus.count);
    end
    wait_ready(lat);
    n_vec++;
    if (lat != LAT) begin
      n_err++;
      $display("FAIL lockout_lat: got %0d exp %0d", lat, LAT);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_run;
    int lat = 0;
    launch(32'h0000B8A6, 16'h6A0E, 16'h4D76, 1'b0);
    while (bus.count != 5'd8 && lat < TMO) begin
      @(negedge clk);
      lat++;
    end
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    n_vec++;
    if ({bus.a_out, bus.ovf, bus.rem_err, bus.busy,
         bus.ready, bus.count} !== '0) begin
      n_err++;
      $display("FAIL mid_reset: got a=%h busy=%b rdy=%b cnt=%0d exp all 0",
               bus.a_out, bus.busy, bus.ready, bus.count);
    end
    repeat (12) @(negedge clk);
    n_vec++;
    if (bus.ready !== 1'b0 || bus.busy !== 1'b0) begin
      n_err++;
      $display("FAIL abort_stays_idle: got rdy=%b busy=%b exp 0/0",
               bus.ready, bus.busy);
    end
    lat = 0;
    launch(32'd3, 16'd7, 16'd2, 1'b1);
    wait_ready(lat);
    n_vec++;
    if (lat != LAT || bus.a_out !== 48'h17) begin
      n_err++;
      $display("FAIL post_reset: got lat=%0d a=%h exp %0d/17",
               lat, bus.a_out, LAT);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int lat = 0;
    launch(32'd2, 16'd3, 16'd1, 1'b1);
    wait_ready(lat);
    lat = 0;
    launch(32'd1, 16'd5, 16'd5, 1'b1);
    n_vec++;
    if (bus.ready !== 1'b0 || bus.busy !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_accept: got rdy=%b busy=%b exp 0/1",
               bus.ready, bus.busy);
    end
    wait_ready(lat);
    n_vec++;
    if (lat != LAT || bus.a_out !== 48'h0A || bus.rem_err !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_result: got lat=%0d a=%h re=%b exp %0d/0a/1",
               lat, bus.a_out, bus.rem_err, LAT);
    end
    @(negedge clk);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.q_in  = '0;
    bus.b_in  = '0;
    bus.r_in  = '0;
    test_reset();
    test_vectors();
    test_busy_lockout();
    test_reset_mid_run();
    test_back_to_back();
    repeat (2) @(negedge clk);
    n_vec++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL sb_drain: got %0d pending exp 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
